// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register:
//   - mode_e        : MODE port encoding
//   - burst_state_e : burst controller FSM states
//   - DIR_RIGHT/LEFT: burst direction encoding (BDIR port)
//   - dp_op_e       : internal datapath operation selected per edge
// ---------------------------------------------------------------------------
package usr_pkg;

    // Operation select on the MODE port (applied only while idle, START=0)
    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTR  = 3'b100,
        MODE_ROTL  = 3'b101,
        MODE_RSVD  = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    // Burst controller states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } burst_state_e;

    // Burst direction, as presented on BDIR
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Datapath operation after MODE / burst arbitration. Rotates are
    // expressed as shifts whose fill bit is taken from the opposite end.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ZERO = 3'd4
    } dp_op_e;

endpackage : usr_pkg

// File: rtl/usr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// usr_burst_ctrl
// Burst sequencer for univ_shift_reg. Holds the IDLE/SHIFT FSM, the burst
// down-counter and the latched direction, and produces registered BUSY and
// DONE. Tells the datapath when a burst shift happens and when MODE applies.
//
// Ports:
//   clk_i        in   clock, rising edge
//   clr_i        in   synchronous active-high clear
//   start_i      in   burst request, sampled while idle
//   bdir_i       in   burst direction (DIR_RIGHT / DIR_LEFT)
//   cnt_i        in   number of burst shifts
//   shift_en_o   out  a burst shift occurs at the coming edge
//   shift_dir_o  out  direction of that shift
//   mode_en_o    out  MODE is honoured at the coming edge
//   busy_o       out  burst in progress (registered)
//   done_o       out  one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             bdir_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             shift_en_o,
    output logic             shift_dir_o,
    output logic             mode_en_o,
    output logic             busy_o,
    output logic             done_o
);

    burst_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;

    // cnt_q holds the number of shifts still to perform, including the one
    // at the coming edge; the edge that sees 1 is the last shift.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        if (cnt_i != '0) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= cnt_i;
                            dir_q   <= bdir_i;
                            busy_q  <= 1'b1;
                        end else begin
                            // Zero-length burst completes immediately
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign shift_en_o  = (state_q == ST_SHIFT);
    assign shift_dir_o = dir_q;
    // A START seen while idle freezes Q for that edge, whatever MODE says
    assign mode_en_o   = (state_q == ST_IDLE) && !start_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule : usr_burst_ctrl

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with hold / shift / load / rotate / clear modes
// and an automatic N-shift burst sequencer.
//
// Parameters:
//   WIDTH  register width (>= 2)
//   CNT_W  width of the burst count
//
// Ports:
//   CLK    in   clock, rising edge
//   CLR    in   synchronous active-high clear (highest priority)
//   MODE   in   operation select (usr_pkg::mode_e)
//   LIN    in   serial fill for left shifts (enters at Q[WIDTH-1])
//   RIN    in   serial fill for right shifts (enters at Q[0])
//   D      in   parallel load data
//   START  in   burst request, sampled while idle
//   BDIR   in   burst direction, 0 = right, 1 = left
//   CNT    in   number of burst shifts
//   Q      out  register contents, Q[0] is the QA end
//   SOR    out  Q[WIDTH-1]
//   SOL    out  Q[0]
//   BUSY   out  burst in progress
//   DONE   out  one-cycle burst completion pulse
// ---------------------------------------------------------------------------
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [2:0]       MODE,
    input  logic             LIN,
    input  logic             RIN,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic             BDIR,
    input  logic [CNT_W-1:0] CNT,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic             BUSY,
    output logic             DONE
);

    logic             shift_en;
    logic             shift_dir;
    logic             mode_en;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    dp_op_e           op;
    logic             rfill;
    logic             lfill;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;

    // -----------------------------------------------------------------------
    // Burst sequencer
    // -----------------------------------------------------------------------
    usr_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_burst_ctrl (
        .clk_i       (CLK),
        .clr_i       (CLR),
        .start_i     (START),
        .bdir_i      (BDIR),
        .cnt_i       (CNT),
        .shift_en_o  (shift_en),
        .shift_dir_o (shift_dir),
        .mode_en_o   (mode_en),
        .busy_o      (BUSY),
        .done_o      (DONE)
    );

    // -----------------------------------------------------------------------
    // Operation select: burst shifts override MODE; MODE applies only when
    // the sequencer allows it. Rotates reuse the shift paths with the fill
    // bit taken from the opposite end of the register.
    // -----------------------------------------------------------------------
    always_comb begin
        op    = OP_HOLD;
        rfill = RIN;
        lfill = LIN;
        if (shift_en) begin
            op = (shift_dir == DIR_LEFT) ? OP_SHL : OP_SHR;
        end else if (mode_en) begin
            unique case (mode_e'(MODE))
                MODE_HOLD:  op = OP_HOLD;
                MODE_SHR:   op = OP_SHR;
                MODE_SHL:   op = OP_SHL;
                MODE_LOAD:  op = OP_LOAD;
                MODE_ROTR: begin
                    op    = OP_SHR;
                    rfill = q_q[WIDTH-1];
                end
                MODE_ROTL: begin
                    op    = OP_SHL;
                    lfill = q_q[0];
                end
                MODE_RSVD:  op = OP_HOLD;
                MODE_CLEAR: op = OP_ZERO;
                default:    op = OP_HOLD;
            endcase
        end
    end

    // Shifted candidates: "right" moves bits toward higher indices
    assign shr_vec = {q_q[WIDTH-2:0], rfill};
    assign shl_vec = {lfill, q_q[WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // Per-bit next-state mux
    // -----------------------------------------------------------------------
    always_comb begin
        q_d = q_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case (op)
                OP_HOLD: q_d[i] = q_q[i];
                OP_SHR:  q_d[i] = shr_vec[i];
                OP_SHL:  q_d[i] = shl_vec[i];
                OP_LOAD: q_d[i] = D[i];
                OP_ZERO: q_d[i] = 1'b0;
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign SOR = q_q[WIDTH-1];
    assign SOL = q_q[0];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed vectors for univ_shift_reg (WIDTH=8, CNT_W=4). Each stimulus
// step pushes its hand-computed expected outputs into a queue; a monitor
// pops one entry after every edge and compares Q, BUSY, DONE, SOR, SOL.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          clr;
    logic [2:0]    mode;
    logic          lin;
    logic          rin;
    logic [W-1:0]  d;
    logic          start;
    logic          bdir;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q;
    logic          sor;
    logic          sol;
    logic          busy;
    logic          done;

    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        string        name;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Left burst, LIN=1, starting from 08: ten shifts
    logic [W-1:0] ltab [10] = '{8'h84, 8'hC2, 8'hE1, 8'hF0, 8'hF8,
                                8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF};

    univ_shift_reg #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .CLK   (clk),
        .CLR   (clr),
        .MODE  (mode),
        .LIN   (lin),
        .RIN   (rin),
        .D     (d),
        .START (start),
        .BDIR  (bdir),
        .CNT   (cnt),
        .Q     (q),
        .SOR   (sor),
        .SOL   (sol),
        .BUSY  (busy),
        .DONE  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs mid-cycle, let one rising edge pass, record expectation
    task automatic step(input logic c, input logic [2:0] m, input logic li,
                        input logic ri, input logic [W-1:0] dd,
                        input logic st, input logic bd, input logic [CW-1:0] n,
                        input logic [W-1:0] eq, input logic eb, input logic ed,
                        input string nm);
        exp_t e;
        @(negedge clk);
        clr   = c;
        mode  = m;
        lin   = li;
        rin   = ri;
        d     = dd;
        start = st;
        bdir  = bd;
        cnt   = n;
        @(posedge clk);
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are sampled on the falling edge after each push
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (q !== e.q) begin
                    fails++;
                    $display("FAIL %s Q: got %h expected %h", e.name, q, e.q);
                end
                tests++;
                if (busy !== e.busy) begin
                    fails++;
                    $display("FAIL %s BUSY: got %b expected %b", e.name, busy, e.busy);
                end
                tests++;
                if (done !== e.done) begin
                    fails++;
                    $display("FAIL %s DONE: got %b expected %b", e.name, done, e.done);
                end
                tests++;
                if (sor !== e.q[W-1]) begin
                    fails++;
                    $display("FAIL %s SOR: got %b expected %b", e.name, sor, e.q[W-1]);
                end
                tests++;
                if (sol !== e.q[0]) begin
                    fails++;
                    $display("FAIL %s SOL: got %b expected %b", e.name, sol, e.q[0]);
                end
            end
        end
    end

    initial begin
        int waited;
        clr = 1'b0; mode = 3'b000; lin = 1'b0; rin = 1'b0;
        d = '0; start = 1'b0; bdir = 1'b0; cnt = '0;

        // Reset beats LOAD and START
        step(1, 3'b011, 0, 0, 8'hFF, 1, 0, 4'd3, 8'h00, 0, 0, "reset");

        // Load / shift
        step(0, 3'b011, 0, 0, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0, "load_a5");
        step(0, 3'b001, 0, 1, 8'h00, 0, 0, 4'd0, 8'h4B, 0, 0, "shr_rin1");
        step(0, 3'b011, 0, 0, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0, "reload_a5");
        step(0, 3'b010, 0, 0, 8'h00, 0, 0, 4'd0, 8'h52, 0, 0, "shl_lin0");

        // Rotate / clear / hold
        step(0, 3'b011, 0, 0, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0, "load_81a");
        step(0, 3'b100, 1, 0, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0, "rotr");
        step(0, 3'b011, 0, 0, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0, "load_81b");
        step(0, 3'b101, 0, 1, 8'h00, 0, 0, 4'd0, 8'hC0, 0, 0, "rotl");
        step(0, 3'b011, 0, 0, 8'hFF, 0, 0, 4'd0, 8'hFF, 0, 0, "load_ff");
        step(0, 3'b111, 1, 1, 8'hFF, 0, 0, 4'd0, 8'h00, 0, 0, "mode_clear");
        step(0, 3'b011, 0, 0, 8'h3C, 0, 0, 4'd0, 8'h3C, 0, 0, "load_3c");
        step(0, 3'b000, 1, 1, 8'hFF, 0, 0, 4'd0, 8'h3C, 0, 0, "hold");
        step(0, 3'b110, 1, 1, 8'hFF, 0, 0, 4'd0, 8'h3C, 0, 0, "reserved");
        step(0, 3'b010, 1, 0, 8'h00, 0, 0, 4'd0, 8'h9E, 0, 0, "shl_lin1");

        // Right burst of 3 with MODE=CLEAR held; START held across final edge
        step(0, 3'b011, 0, 0, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0, "load_01");
        step(0, 3'b111, 0, 0, 8'h00, 1, 0, 4'd3, 8'h01, 1, 0, "b3_start");
        step(0, 3'b111, 0, 0, 8'hFF, 1, 1, 4'd7, 8'h02, 1, 0, "b3_s1");
        step(0, 3'b111, 0, 0, 8'hFF, 1, 1, 4'd7, 8'h04, 1, 0, "b3_s2");
        step(0, 3'b111, 0, 0, 8'hFF, 1, 1, 4'd7, 8'h08, 0, 1, "b3_s3");
        step(0, 3'b000, 0, 0, 8'h00, 0, 0, 4'd0, 8'h08, 0, 0, "b3_after");

        // Left burst longer than WIDTH, inputs toggled during burst
        step(0, 3'b000, 1, 0, 8'h00, 1, 1, 4'd10, 8'h08, 1, 0, "b10_start");
        for (int i = 0; i < 10; i++) begin
            step(0, 3'b011, 1, 0, 8'h55, 1, 0, 4'd0, ltab[i],
                 (i < 9) ? 1'b1 : 1'b0, (i == 9) ? 1'b1 : 1'b0, "b10_shift");
        end
        step(0, 3'b000, 0, 0, 8'h00, 0, 0, 4'd0, 8'hFF, 0, 0, "b10_after");

        // Abort by CLR after first shift, restart two cycles later
        step(0, 3'b011, 0, 0, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0, "ab_load");
        step(0, 3'b000, 0, 1, 8'h00, 1, 0, 4'd4, 8'h01, 1, 0, "ab_start");
        step(0, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h03, 1, 0, "ab_s1");
        step(1, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, "ab_clr");
        step(0, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, "ab_idle");
        step(0, 3'b000, 0, 1, 8'h00, 1, 0, 4'd2, 8'h00, 1, 0, "rs_start");
        step(0, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h01, 1, 0, "rs_s1");
        step(0, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h03, 0, 1, "rs_s2");
        step(0, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0, "rs_after");

        // Zero count
        step(0, 3'b111, 0, 0, 8'h00, 1, 0, 4'd0, 8'h03, 0, 1, "zc_start");
        step(0, 3'b000, 0, 0, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0, "zc_after");

        // CNT=1 bursts back to back
        step(0, 3'b000, 0, 0, 8'h00, 1, 1, 4'd1, 8'h03, 1, 0, "c1_start");
        step(0, 3'b000, 0, 0, 8'h00, 0, 0, 4'd0, 8'h01, 0, 1, "c1_shl");
        step(0, 3'b000, 0, 1, 8'h00, 1, 0, 4'd1, 8'h01, 1, 0, "c1b_start");
        step(0, 3'b000, 0, 1, 8'h00, 0, 0, 4'd0, 8'h03, 0, 1, "c1b_shr");
        step(0, 3'b000, 0, 0, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0, "c1_after");

        // Idle clear overrides LOAD
        step(1, 3'b011, 0, 0, 8'hAA, 0, 0, 4'd0, 8'h00, 0, 0, "clr_idle");

        // Drain scoreboard with a bounded wait
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_univ_shift_reg
